except_commit: RTL

Exception commit unit at the tail of the MEM stage. It consumes the per-instruction exception vector produced by MEM-stage address checking, along with the instruction context. It resolves priority among interrupt, exception and ERET, and waits for any in-flight data-memory access to drain. It then issues a one-cycle pipeline flush with the redirect PC and the CP0 update strobes (EPC, BadVAddr, Cause.ExcCode/BD, Status.EXL).

---
 rtl/except_commit.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/except_commit.sv
// except_commit
//   Exception commit unit at the tail of the MEM stage. It resolves priority
//   among interrupt, the decoded exception bits and ERET, then waits for any
//   outstanding data-memory access to drain. After that it emits a one-cycle
//   flush with the redirect PC and the CP0 update strobes.
//
// Ports
//   clk, resetn          core clock, asynchronous active-low reset
//   valid_i              MEM-stage instruction valid
//   excepttype_i[31:0]   exception vector (decoded bit positions below)
//   is_eret_i            instruction is ERET
//   pc_i, access_addr_i, branch_target_i, in_delay_slot_i   instruction context
//   int_pending_i        unmasked interrupt request
//   status_exl_i, epc_i  current CP0 Status.EXL and EPC
//   mem_busy_i           data-memory request outstanding
//   stall_o, flush_o, new_pc_o                       pipeline control
//   epc_we_o/epc_o/bd_o, badvaddr_we_o/badvaddr_o,
//   cause_we_o/exccode_o, set_exl_o, clr_exl_o       CP0 update port
//   All outputs are registered and are zero outside the FLUSH cycle,
//   except stall_o, which is high while waiting for memory to drain.
module except_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  logic [31:0] excepttype_i,
  input  logic        is_eret_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] access_addr_i,
  input  logic [31:0] branch_target_i,
  input  logic        in_delay_slot_i,
  input  logic        int_pending_i,
  input  logic        status_exl_i,
  input  logic [31:0] epc_i,
  input  logic        mem_busy_i,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        epc_we_o,
  output logic [31:0] epc_o,
  output logic        bd_o,
  output logic        badvaddr_we_o,
  output logic [31:0] badvaddr_o,
  output logic        cause_we_o,
  output logic [4:0]  exccode_o,
  output logic        set_exl_o,
  output logic        clr_exl_o
);

  // Bit positions inside excepttype_i (excepttions.vh layout).
  localparam int BIT_ADEL_IF = 0;
  localparam int BIT_ADEL_LD = 1;
  localparam int BIT_ADES    = 2;
  localparam int BIT_SYS     = 3;
  localparam int BIT_BP      = 4;
  localparam int BIT_RI      = 5;
  localparam int BIT_OV      = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  // Everything that is committed in the FLUSH cycle.
  typedef struct packed {
    logic [31:0] new_pc;
    logic        epc_we;
    logic [31:0] epc;
    logic        bd;
    logic        badvaddr_we;
    logic [31:0] badvaddr;
    logic        cause_we;
    logic [4:0]  exccode;
    logic        set_exl;
    logic        clr_exl;
  } commit_t;

  state_e  state_q, state_d;
  commit_t cap_q, cap_d;     // winner captured at accept
  commit_t out_q, out_d;     // registered output record
  logic    flush_q, flush_d;
  logic    stall_q, stall_d;

  commit_t     ev_s;
  logic        trigger_s;
  logic [6:0]  dec_s;
  logic [31:0] epc_norm_s;
  logic        unused_bits_s;

  assign dec_s = excepttype_i[6:0];
  assign unused_bits_s = ^excepttype_i[31:7];

  // Priority resolution of the current MEM-stage instruction into a commit record.
  always_comb begin
    trigger_s  = valid_i & (int_pending_i | (|dec_s) | is_eret_i);
    epc_norm_s = in_delay_slot_i ? (pc_i - 32'd4) : pc_i;
    ev_s             = '0;
    ev_s.new_pc      = EXC_VECTOR;
    ev_s.epc_we      = ~status_exl_i;
    ev_s.epc         = epc_norm_s;
    ev_s.bd          = in_delay_slot_i;
    ev_s.cause_we    = 1'b1;
    ev_s.set_exl     = 1'b1;
    if (int_pending_i) begin
      ev_s.exccode = 5'd0;
    end else if (dec_s[BIT_ADEL_IF]) begin
      // Fetch fault on a branch target: the faulting PC is the target itself.
      ev_s.exccode     = 5'd4;
      ev_s.epc         = branch_target_i;
      ev_s.bd          = 1'b0;
      ev_s.badvaddr_we = 1'b1;
      ev_s.badvaddr    = branch_target_i;
    end else if (dec_s[BIT_RI]) begin
      ev_s.exccode = 5'd10;
    end else if (dec_s[BIT_OV]) begin
      ev_s.exccode = 5'd12;
    end else if (dec_s[BIT_SYS]) begin
      ev_s.exccode = 5'd8;
    end else if (dec_s[BIT_BP]) begin
      ev_s.exccode = 5'd9;
    end else if (dec_s[BIT_ADEL_LD]) begin
      ev_s.exccode     = 5'd4;
      ev_s.badvaddr_we = 1'b1;
      ev_s.badvaddr    = access_addr_i;
    end else if (dec_s[BIT_ADES]) begin
      ev_s.exccode     = 5'd5;
      ev_s.badvaddr_we = 1'b1;
      ev_s.badvaddr    = access_addr_i;
    end else begin
      // ERET (or no trigger, in which case the record is unused).
      ev_s         = '0;
      ev_s.new_pc  = epc_i;
      ev_s.clr_exl = 1'b1;
    end
  end

  // Commit FSM: next state, capture registers and next output values.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    out_d   = '0;
    flush_d = 1'b0;
    stall_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger_s) begin
          cap_d = ev_s;
          if (mem_busy_i) begin
            state_d = S_WAIT;
            stall_d = 1'b1;
          end else begin
            state_d = S_FLUSH;
            flush_d = 1'b1;
            out_d   = ev_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!mem_busy_i) begin
          state_d = S_FLUSH;
          flush_d = 1'b1;
          out_d   = cap_q;
        end else begin
          stall_d = 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      out_q   <= '0;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
    end
  end

  assign stall_o       = stall_q;
  assign flush_o       = flush_q;
  assign new_pc_o      = out_q.new_pc;
  assign epc_we_o      = out_q.epc_we;
  assign epc_o         = out_q.epc;
  assign bd_o          = out_q.bd;
  assign badvaddr_we_o = out_q.badvaddr_we;
  assign badvaddr_o    = out_q.badvaddr;
  assign cause_we_o    = out_q.cause_we;
  assign exccode_o     = out_q.exccode;
  assign set_exl_o     = out_q.set_exl;
  assign clr_exl_o     = out_q.clr_exl;

endmodule
